// File: rtl/dendy_pkg.sv
// Shared DMA state encoding and bus addresses for the OAM DMA engine.
package dendy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_RD    = 3'd3,
        ST_WR    = 3'd4
    } dma_state_e;

    localparam logic [15:0] DMA_TRIG = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to DMA_TRIG halts the CPU and copies 256 bytes of a page into OAM_DATA.
// Macro OAM_DMA_ALIGN_EN adds the odd-parity ALIGN cycle (514-cycle stall); undefined gives a fixed 513.
module oam_dma
    import dendy_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic        cpu_ce,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_o,
    output logic        bus_r,
    output logic        bus_w,
    input  logic [7:0]  bus_i,
    output logic        busy,
    output dma_state_e  dbg_state_o
);

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] dr_q, dr_d;
`ifdef OAM_DMA_ALIGN_EN
    logic       parity_q;
`endif

    // Every register advances only on CPU-rate enable pulses; reset ignores ce.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            dr_q     <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else if (ce) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            dr_q     <= dr_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        dr_d    = dr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_w && (cpu_a == DMA_TRIG)) begin
                    state_d = ST_HALT;
                    page_d  = cpu_d;
                    idx_d   = 8'h00;
                end
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ST_ALIGN : ST_RD;
`else
                state_d = ST_RD;
`endif
            end
            ST_ALIGN: state_d = ST_RD;
            ST_RD: begin
                state_d = ST_WR;
                dr_d    = bus_i;
            end
            ST_WR: begin
                idx_d   = idx_q + 8'h01;
                state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_RD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus mux: the CPU owns the bus in IDLE; HALT/ALIGN keep its address but no strobes.
    always_comb begin
        bus_a = cpu_a;
        bus_o = cpu_d;
        bus_r = 1'b0;
        bus_w = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus_r = cpu_r;
                bus_w = cpu_w;
            end
            ST_RD: begin
                bus_a = {page_q, idx_q};
                bus_o = dr_q;
                bus_r = 1'b1;
            end
            ST_WR: begin
                bus_a = OAM_DATA;
                bus_o = dr_q;
                bus_w = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_ce      = ce && (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table-driven idle vectors plus randomized DMA runs against a phase-based model.
module tb_oam_dma;
  import dendy_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // clock / reset block
  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_r = 1'b0;
  logic        cpu_w = 1'b0;
  logic        cpu_ce;
  logic [15:0] bus_a;
  logic [7:0]  bus_o;
  logic        bus_r;
  logic        bus_w;
  logic [7:0]  bus_i;
  logic        busy;
  dma_state_e  dbg_state;

  oam_dma dut (
    .clock(clock), .reset_n(reset_n), .ce(ce),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w),
    .cpu_ce(cpu_ce), .bus_a(bus_a), .bus_o(bus_o), .bus_r(bus_r), .bus_w(bus_w),
    .bus_i(bus_i), .busy(busy), .dbg_state_o(dbg_state)
  );

  // memory: byte at {page, i} is mem[i] ^ page
  logic [7:0] mem [256];
  assign bus_i = mem[bus_a[7:0]] ^ bus_a[15:8];

  int vectors = 0;
  int miscompares = 0;

  // reference model: DMA progress counted in ce edges since the trigger edge
  bit         m_active = 1'b0;
  int         m_n = 0;
  int         m_a = 0;
  logic [7:0] m_page = 8'h00;
  int         ce_cnt = 0;
  int         stall_cnt = 0;
  int         wr_cnt = 0;
  bit         checks_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_now();
    logic [15:0] ea;
    logic        er, ew;
    logic [7:0]  kb;
    int          k;
    if (m_active) begin
      cmp("busy", busy, 1);
      cmp("cpu_ce", cpu_ce, 0);
      if (m_n == 0 || (m_a == 1 && m_n == 1)) begin
        ea = cpu_a; er = 1'b0; ew = 1'b0;
      end else begin
        k  = m_n - 1 - m_a;
        kb = k[8:1];
        if (k % 2 == 0) begin
          ea = {m_page, kb}; er = 1'b1; ew = 1'b0;
        end else begin
          ea = OAM_DATA; er = 1'b0; ew = 1'b1;
          cmp("bus_o_wr", bus_o, mem[kb] ^ m_page);
        end
      end
    end else begin
      cmp("busy", busy, 0);
      cmp("cpu_ce", cpu_ce, ce);
      cmp("bus_o_pass", bus_o, cpu_d);
      ea = cpu_a; er = cpu_r; ew = cpu_w;
    end
    cmp("bus_a", bus_a, ea);
    cmp("bus_r", bus_r, er);
    cmp("bus_w", bus_w, ew);
    if (ce && !cpu_ce) stall_cnt++;
    if (ce && bus_w && m_active && bus_a == OAM_DATA) begin
      wr_cnt++;
      if (exp_q.size() == 0) cmp("oam_extra_write", 1, 0);
      else cmp("oam_byte", bus_o, exp_q.pop_front());
    end
  endtask

  // driver: one clock; outputs checked just after the falling edge, model stepped at the rising edge
  task automatic tick(input logic ce_v, input logic rst_v);
    @(negedge clock);
    ce = ce_v;
    reset_n = rst_v;
    #1;
    if (checks_en) check_now();
    @(posedge clock);
    if (!rst_v) begin
      m_active = 1'b0;
      ce_cnt = 0;
      exp_q.delete();
    end else if (ce_v) begin
      ce_cnt++;
      if (m_active) begin
        m_n++;
        if (m_n == 513 + m_a) m_active = 1'b0;
      end else if (cpu_w && cpu_a == DMA_TRIG) begin
        m_active = 1'b1;
        m_n = 0;
        m_page = cpu_d;
        m_a = (ALIGN_EN && (ce_cnt % 2 == 1)) ? 1 : 0;
        stall_cnt = 0;
        wr_cnt = 0;
        for (int i = 0; i < 256; i++) exp_q.push_back(mem[i] ^ cpu_d);
      end
    end
    #1;
  endtask

  task automatic rand_cpu();
    cpu_a = ($urandom_range(0, 3) == 0) ? DMA_TRIG : 16'($urandom);
    cpu_d = 8'($urandom);
    cpu_r = 1'($urandom);
    cpu_w = 1'($urandom);
    if (m_n >= 512 + m_a) cpu_w = 1'b0;
  endtask

  // want_par: parity register value seen in HALT; abort: reset when idx reaches 8'h80
  task automatic run_dma(input logic [7:0] pg, input int period, input bit want_par, input bit abort);
    int exp_stall;
    cpu_w = 1'b0; cpu_r = 1'b0;
    if ((ce_cnt % 2) != (want_par ? 0 : 1)) tick(1, 1);
    cpu_a = DMA_TRIG; cpu_w = 1'b1; cpu_d = pg;
    tick(1, 1);
    cmp("trigger_busy", busy, 1);
    exp_stall = (ALIGN_EN && want_par) ? 514 : 513;
    for (int c = 0; c < 2000 && m_active; c++) begin
      if (abort && m_n == 257 + m_a) break;
      rand_cpu();
      tick(1, 1);
      for (int p = 1; p < period; p++) tick(0, 1);
    end
    cpu_w = 1'b0;
    if (abort) begin
      cmp("abort_at_idx80", bus_a, {pg, 8'h80});
      tick(0, 0);
      cmp("abort_busy", busy, 0);
      tick(1, 1);
      tick(0, 1);
      tick(1, 1);
      cmp("abort_idle_busy", busy, 0);
    end else if (m_active) begin
      cmp("dma_timeout", 1, 0);
    end else begin
      cmp("stall_cycles", stall_cnt, exp_stall);
      cmp("oam_writes", wr_cnt, 256);
      cmp("oam_queue_left", exp_q.size(), 0);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    logic        w;
    logic        ce;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    tick(1, 0);
    tick(0, 0);
    checks_en = 1'b1;
    cmp("reset_busy", busy, 0);
    cmp("reset_bus_w", bus_w, 0);
    tick(1, 1);

    // idle vectors: none of these may start a DMA
    tbl[0] = '{16'h4015, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'h4013, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h4014, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h2004, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h0200, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cpu_a = tbl[i].a; cpu_d = tbl[i].d; cpu_r = tbl[i].r; cpu_w = tbl[i].w;
      tick(tbl[i].ce, 1);
      cmp("table_busy", busy, tbl[i].exp_busy);
    end
    cpu_w = 1'b0;
    tick(1, 1);

    run_dma(8'h02, 1, 1'b0, 1'b0);
    run_dma(8'h02, 1, 1'b1, 1'b0);
    run_dma(8'($urandom), 3, 1'($urandom), 1'b0);
    run_dma(8'h02, 1, 1'($urandom), 1'b1);
    run_dma(8'($urandom), 1, 1'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port clock, input, 1 bit: system clock, 25 MHz.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port ce, input, 1 bit: CPU-rate clock enable; one pulse marks one CPU cycle.
REQ-004 SHALL have port cpu_a, input, 16 bits: CPU address.
REQ-005 SHALL have port cpu_d, input, 8 bits: CPU write data.
REQ-006 SHALL have ports cpu_r and cpu_w, input, 1 bit each: CPU read and write strobes.
REQ-007 SHALL have port cpu_ce, output, 1 bit: gated enable to the CPU.
REQ-008 SHALL have port bus_a, output, 16 bits: arbitrated bus address.
REQ-009 SHALL have port bus_o, output, 8 bits: arbitrated bus write data.
REQ-010 SHALL have ports bus_r and bus_w, output, 1 bit each: arbitrated bus read and write strobes.
REQ-011 SHALL have port bus_i, input, 8 bits: bus read data.
REQ-012 SHALL have port busy, output, 1 bit: DMA in progress.

Function
REQ-013 SHALL update all state only on clocks with ce=1; with ce=0, all registers hold.
REQ-014 SHALL implement the states IDLE, HALT, ALIGN, RD and WR.
REQ-015 SHALL compute cpu_ce = ce AND (state==IDLE), combinationally.
REQ-016 SHALL leave IDLE for HALT on a ce clock with cpu_w=1 and cpu_a=16'h4014; on that clock it SHALL latch page <= cpu_d and clear the 8-bit index idx.
REQ-017 SHALL ignore cpu_w to 16'h4014 while not in IDLE, and SHALL ignore all other addresses, including 16'h4015.
REQ-018 SHALL toggle a parity register on every ce clock, including clocks during DMA.
REQ-019 SHALL go from HALT to ALIGN when parity=1, and otherwise to RD.
REQ-020 SHALL go from ALIGN to RD.
REQ-021 In RD, SHALL drive bus_a={page,idx}, bus_r=1 and bus_w=0, then go to WR.
REQ-022 On entering WR, SHALL latch bus_i into the data register dr.
REQ-023 In WR, SHALL drive bus_a=16'h2004, bus_o=dr, bus_w=1 and bus_r=0.
REQ-024 On leaving WR, SHALL increment idx; when idx wrapped 8'hFF->8'h00, SHALL go to IDLE, otherwise to RD.
REQ-025 In IDLE, SHALL pass bus_a, bus_o, bus_r and bus_w through from cpu_a, cpu_d, cpu_r and cpu_w.
REQ-026 In HALT and ALIGN, SHALL drive bus_a=cpu_a with bus_r=bus_w=0.
REQ-027 SHALL assert busy whenever state is not IDLE.
REQ-028 SHALL hold cpu_ce=0 for exactly 513 ce cycles with even parity and 514 with odd parity.
REQ-029 SHALL let the CPU complete its step on the triggering ce clock; the halt begins on the next ce clock.
REQ-030 SHALL NOT affect NMI; the CPU samples NMI only when cpu_ce=1, so an NMI during DMA is taken afterwards.

Reset
REQ-031 SHALL, while reset_n=0 on a clock edge, set state=IDLE, parity=0, idx=0, page=0, dr=0 and busy=0, regardless of ce.
REQ-032 SHALL abort a DMA on reset mid-transfer: no further bus_w, and cpu_ce follows ce from the first clock after reset.

Configuration
REQ-033 SHALL provide macro OAM_DMA_ALIGN_EN.
REQ-034 With OAM_DMA_ALIGN_EN defined, SHALL insert the ALIGN state per REQ-019.
REQ-035 Without OAM_DMA_ALIGN_EN, SHALL always go HALT->RD, giving a fixed 513-cycle stall; the parity register MAY be removed.

Structure
REQ-036 SHALL place the state encoding and constants DMA_TRIG=16'h4014 and OAM_DATA=16'h2004 in shared package dendy_pkg.
REQ-037 SHALL be a single module with no sub-module; the bus mux is inline.

Verification
REQ-038 SHALL cover: parity=0, CPU writes 8'h02 to 16'h4014 -> busy for 513 ce cycles; 256 bus_w pulses to 16'h2004 carry bytes from 16'h0200..16'h02FF in order.
REQ-039 SHALL cover: same write with parity=1 and the macro defined -> 514 stalled ce cycles with identical data order.
REQ-040 SHALL cover: same write with parity=1 and the macro undefined -> 513 stalled ce cycles.
REQ-041 SHALL cover: CPU writes to 16'h4015 -> no DMA, busy=0, and bus signals equal the CPU signals.
REQ-042 SHALL cover: reset_n=0 at idx=8'h80 -> IDLE on the next clock, bus_w=0, and cpu_ce follows ce.
REQ-043 SHALL cover: ce pulsing once every 3 clocks during DMA -> bus outputs and idx hold between pulses, and the cycle count is unchanged.
